// File: rtl/arb_request_sequencer_pkg.sv
// rtl/arb_request_sequencer_pkg.sv - shared state encodings and defaults for the ICE bus sequencers
package arb_request_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SERVE   = 3'd3,
        ST_RELEASE = 3'd4
    } seq_state_t;

    localparam int DEFAULT_TIMEOUT = 1000;
    localparam int DEFAULT_TO_W    = 16;

endpackage

// File: rtl/arb_request_sequencer_sat_timeout_counter.sv
// rtl/arb_request_sequencer_sat_timeout_counter.sv - saturating service timeout counter
module sat_timeout_counter #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Count enabled cycles; hold at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // The count is zero on the first enabled cycle, so this fires on enabled cycle number TIMEOUT.
    assign expire = enable && (count == LAST);

endmodule

// File: rtl/arb_request_sequencer.sv
// rtl/arb_request_sequencer.sv - pends client requests, drives the arbiter and sequences one service per grant
module arb_request_sequencer
    import arb_request_sequencer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = DEFAULT_TO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] arb_requests,
    output logic             arb_enable,
    output logic             arb_latch,
    input  logic [WIDTH-1:0] arb_grants,
    input  logic             arb_granted,
    output logic             svc_valid,
    output logic [WIDTH-1:0] svc_sel,
    input  logic             svc_done,
    output logic [WIDTH-1:0] ack,
    output logic             svc_timeout
);

    seq_state_t       state;
    seq_state_t       state_n;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] sel_q;
    logic             abort_q;
    logic             expire;
    logic             in_serve;

    assign in_serve = (state == ST_SERVE);

    sat_timeout_counter #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_serve),
        .enable (in_serve),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and control outputs; everything defaults to idle/zero.
    always_comb begin
        state_n     = state;
        arb_enable  = 1'b0;
        arb_latch   = 1'b0;
        svc_valid   = 1'b0;
        svc_sel     = '0;
        ack         = '0;
        svc_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                // Looking at req_in too lets a fresh request reach ARB the very next cycle.
                if (|(pending_q | req_in)) begin
                    state_n = ST_ARB;
                end
            end
            ST_ARB: begin
                arb_enable = 1'b1;
                arb_latch  = 1'b1;
                state_n    = ST_WAIT;
            end
            ST_WAIT: begin
                // A grant that misses every live request should not happen; fall back to IDLE.
                if (arb_granted) begin
                    state_n = ST_SERVE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SERVE: begin
                svc_valid = 1'b1;
                svc_sel   = sel_q;
                if (svc_done || expire) begin
                    state_n = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                ack         = sel_q;
                svc_timeout = abort_q;
                // Latch with enable low so the arbiter drops its grant.
                arb_latch   = 1'b1;
                state_n     = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Sticky pending bits, captured grant and abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            sel_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            // New requests override the clearing ack on the same bit.
            pending_q <= (pending_q & ~ack) | req_in;
            if ((state == ST_WAIT) && arb_granted) begin
                sel_q <= arb_grants;
            end else if (state == ST_RELEASE) begin
                sel_q <= '0;
            end
            // Done on the expiry cycle counts as a normal completion.
            if (in_serve) begin
                abort_q <= expire && !svc_done;
            end else if (state == ST_RELEASE) begin
                abort_q <= 1'b0;
            end
        end
    end

    assign pending      = pending_q;
    assign arb_requests = pending_q;

endmodule

// File: tb/tb_arb_request_sequencer.sv
// tb/tb_arb_request_sequencer.sv - self-checking bench for arb_request_sequencer with a behavioural arbiter
module tb_arb_request_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = '0;
    logic [7:0] pending;
    logic [7:0] arb_requests;
    logic       arb_enable;
    logic       arb_latch;
    logic [7:0] arb_grants;
    logic       arb_granted;
    logic       svc_valid;
    logic [7:0] svc_sel;
    logic       svc_done = 1'b0;
    logic [7:0] ack;
    logic       svc_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] sel;
        logic       to;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] req;
        int         delay;
        logic [7:0] sel;
        logic       to;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-priority arbiter: registered one-hot grant, lowest index wins.
    always @(posedge clk) begin
        if (rst) arb_grants <= 8'h00;
        else if (arb_latch) arb_grants <= arb_enable ? (arb_requests & (~arb_requests + 8'd1)) : 8'h00;
    end
    assign arb_granted = |(arb_grants & arb_requests);

    arb_request_sequencer #(
        .WIDTH   (8),
        .TIMEOUT (16),
        .TO_W    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .pending      (pending),
        .arb_requests (arb_requests),
        .arb_enable   (arb_enable),
        .arb_latch    (arb_latch),
        .arb_grants   (arb_grants),
        .arb_granted  (arb_granted),
        .svc_valid    (svc_valid),
        .svc_sel      (svc_sel),
        .svc_done     (svc_done),
        .ack          (ack),
        .svc_timeout  (svc_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard on acks, plus minimum spacing between service starts.
    logic prev_valid = 1'b0;
    int   last_rise  = -1;
    always @(negedge clk) begin
        if (!rst && (ack != 8'h00)) begin
            check("ack_onehot", 32'($onehot(ack)), 1);
            if (sb.size() == 0) begin
                check("ack_unexpected", ack, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_client", ack, e.sel);
                check("ack_timeout_flag", svc_timeout, e.to);
            end
        end
        if (svc_valid && !prev_valid) begin
            if (last_rise >= 0) check("valid_gap_min5", 32'((cyc - last_rise) >= 5), 1);
            last_rise = cyc;
        end
        prev_valid = svc_valid;
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (svc_valid) seen = 1'b1;
        end
        check("svc_valid_seen", 32'(seen), 1);
    endtask

    // One service: delay>=0 pulses done after that many extra SERVE cycles, delay<0 lets it time out.
    task automatic run_txn(input logic [7:0] sel, input int delay);
        bit seen;
        wait_valid(seen);
        if (!seen) return;
        check("svc_sel", svc_sel, sel);
        if (delay >= 0) begin
            repeat (delay) advance();
            svc_done = 1'b1;
            advance();
            svc_done = 1'b0;
        end else begin
            int n = 1;
            for (int i = 0; i < 40; i++) begin
                advance();
                if (!svc_valid) break;
                n++;
            end
            check("serve_cycles_before_timeout", n, 16);
        end
        check("release_ack", ack, sel);
        check("release_sel_zero", svc_sel, 0);
        advance();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        vecs[0] = '{8'h90,  2, 8'h10, 1'b0};
        vecs[1] = '{8'h00,  1, 8'h80, 1'b0};
        vecs[2] = '{8'h01, -1, 8'h01, 1'b1};
        vecs[3] = '{8'h20,  0, 8'h20, 1'b0};
        vecs[4] = '{8'h40, 15, 8'h40, 1'b0};
        vecs[5] = '{8'h06,  3, 8'h02, 1'b0};
        vecs[6] = '{8'h00,  0, 8'h04, 1'b0};

        rst = 1'b1;
        advance();
        advance();
        check("reset_outputs",
              {8'h00, pending, svc_sel, ack, 4'h0, arb_enable, arb_latch, svc_valid, svc_timeout}, 0);
        rst = 1'b0;
        advance();

        // Basic latency: request at cycle 0, select at 3, done at 5, ack at 6.
        req_in = 8'h04;
        sb.push_back('{8'h04, 1'b0});
        advance();
        req_in = 8'h00;
        check("c1_arb_strobe", {arb_enable, arb_latch}, 2'b11);
        check("c1_not_valid", svc_valid, 0);
        advance();
        check("c2_grant", arb_grants, 8'h04);
        check("c2_not_valid", svc_valid, 0);
        advance();
        check("c3_valid", svc_valid, 1);
        check("c3_sel", svc_sel, 8'h04);
        advance();
        advance();
        svc_done = 1'b1;
        advance();
        svc_done = 1'b0;
        check("c6_ack", ack, 8'h04);
        check("c6_sel_zero", svc_sel, 0);
        advance();
        check("c7_pending_clear", pending, 8'h00);
        check("c7_grant_clear", arb_grants, 8'h00);

        // Table of transactions.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].req != 8'h00) begin
                req_in = vecs[i].req;
                advance();
                req_in = 8'h00;
            end
            sb.push_back('{vecs[i].sel, vecs[i].to});
            run_txn(vecs[i].sel, vecs[i].delay);
        end

        // Re-request landing on the ack cycle must stay pending and be served again.
        req_in = 8'h04;
        sb.push_back('{8'h04, 1'b0});
        advance();
        req_in = 8'h00;
        wait_valid(seen);
        svc_done = 1'b1;
        advance();
        svc_done = 1'b0;
        req_in = 8'h04;
        sb.push_back('{8'h04, 1'b0});
        check("rereq_ack", ack, 8'h04);
        advance();
        req_in = 8'h00;
        check("rereq_pending_kept", pending, 8'h04);
        run_txn(8'h04, 1);

        // Reset mid-SERVE aborts silently.
        req_in = 8'h08;
        advance();
        req_in = 8'h00;
        wait_valid(seen);
        advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        check("rst_outputs_zero",
              {8'h00, pending, svc_sel, ack, 4'h0, arb_enable, arb_latch, svc_valid, svc_timeout}, 0);
        check("rst_grant_zero", arb_grants, 8'h00);
        repeat (6) advance();
        check("rst_stays_idle", {pending, svc_valid}, 0);

        req_in = 8'h02;
        sb.push_back('{8'h02, 1'b0});
        advance();
        req_in = 8'h00;
        run_txn(8'h02, 0);

        repeat (4) advance();
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
